// File: rtl/seq_lock_pkg.sv
// Shared state encoding and width helpers for the sequential combination lock.
package seq_lock_pkg;

    localparam logic [1:0] StEntry    = 2'd0;
    localparam logic [1:0] StUnlocked = 2'd1;
    localparam logic [1:0] StProgram  = 2'd2;
    localparam logic [1:0] StLockout  = 2'd3;

    function automatic int unsigned step_w(input int unsigned n_steps);
        return $clog2(n_steps);
    endfunction

    function automatic int unsigned fail_w(input int unsigned max_fail);
        return $clog2(max_fail + 1);
    endfunction

    function automatic int unsigned timer_w(input int unsigned unlock_cyc,
                                            input int unsigned lockout_cyc);
        return $clog2(((unlock_cyc > lockout_cyc) ? unlock_cyc : lockout_cyc) + 1);
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registers a level input and flags the cycle in which it first samples high.
module edge_detect_rise (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign q_o    = d_q;
    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/seq_lock.sv
// Sequential combination lock with timed unlock window, failure lockout and
// in-field code reprogramming while unlocked.
module seq_lock
    import seq_lock_pkg::*;
#(
    parameter int unsigned CODE_W      = 5,
    parameter int unsigned N_STEPS     = 3,
    parameter logic [N_STEPS*CODE_W-1:0] DEFAULT_CODE = {5'h1D, 5'h0C, 5'h10},
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter int unsigned UNLOCK_CYC  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [CODE_W-1:0]                    code_in_i,
    input  logic                                 enter_i,
    input  logic                                 prog_en_i,
    output logic                                 unlocked_o,
    output logic                                 locked_out_o,
    output logic                                 prog_active_o,
    output logic [step_w(N_STEPS)-1:0]           step_o,
    output logic [fail_w(MAX_FAIL)-1:0]          fail_cnt_o
);

    localparam int unsigned StepW  = step_w(N_STEPS);
    localparam int unsigned FailW  = fail_w(MAX_FAIL);
    localparam int unsigned TimerW = timer_w(UNLOCK_CYC, LOCKOUT_CYC);
    localparam int unsigned CodeW  = N_STEPS * CODE_W;

    localparam logic [StepW-1:0]  LastStep   = StepW'(N_STEPS - 1);
    localparam logic [FailW-1:0]  LastFail   = FailW'(MAX_FAIL - 1);
    localparam logic [TimerW-1:0] UnlockLoad = TimerW'(UNLOCK_CYC - 1);
    localparam logic [TimerW-1:0] LockLoad   = TimerW'(LOCKOUT_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic [StepW-1:0]  step_q, step_d;
    logic [FailW-1:0]  fail_q, fail_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CodeW-1:0]  code_q, code_d;
    logic [CodeW-1:0]  shadow_q, shadow_d;
    logic              enter_q;
    logic              enter_rise;
    logic [CODE_W-1:0] cur_digit;

    edge_detect_rise u_enter_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (enter_i),
        .q_o    (enter_q),
        .rise_o (enter_rise)
    );

    assign cur_digit = code_q[step_q*CODE_W +: CODE_W];

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        case (state_q)
            StEntry: begin
                if (enter_rise) begin
                    if (code_in_i == cur_digit) begin
                        if (step_q == LastStep) begin
                            state_d = StUnlocked;
                            step_d  = '0;
                            fail_d  = '0;
                            timer_d = UnlockLoad;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        // A wrong digit restarts the sequence; it is not retried as digit 0.
                        step_d = '0;
                        if (fail_q == LastFail) begin
                            state_d = StLockout;
                            timer_d = LockLoad;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_q + 1'b1;
                        end
                    end
                end
            end
            StUnlocked: begin
                if (enter_rise && prog_en_i) begin
                    state_d = StProgram;
                    step_d  = '0;
                end else if (timer_q == '0) begin
                    state_d = StEntry;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StProgram: begin
                if (!prog_en_i) begin
                    state_d  = StEntry;
                    step_d   = '0;
                    shadow_d = '0;
                end else if (enter_rise) begin
                    shadow_d[step_q*CODE_W +: CODE_W] = code_in_i;
                    if (step_q == LastStep) begin
                        // Commit all digits in one clock so a half-written code is never live.
                        code_d   = shadow_d;
                        shadow_d = '0;
                        state_d  = StEntry;
                        step_d   = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StLockout: begin
                if (timer_q == '0) begin
                    state_d = StEntry;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = StEntry;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StEntry;
            step_q   <= '0;
            fail_q   <= '0;
            timer_q  <= '0;
            code_q   <= DEFAULT_CODE;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            code_q   <= code_d;
            shadow_q <= shadow_d;
        end
    end

    assign unlocked_o    = (state_q == StUnlocked);
    assign locked_out_o  = (state_q == StLockout);
    assign prog_active_o = (state_q == StProgram);
    assign step_o        = step_q;
    assign fail_cnt_o    = fail_q;

    logic unused_enter_q;
    assign unused_enter_q = enter_q;

endmodule

// File: doc/seq_lock.md
Name: seq_lock

Overview:
- Parametrised sequential combination lock. A user enters N_STEPS digits of CODE_W bits, one per rising edge of a strobe.
- Adds the following features:
  - a timed unlock window;
  - a failure counter with timed lockout;
  - in-field reprogramming of the code while unlocked.
- Sits behind the tile IO wrapper. Digits, strobe and program-enable come from user inputs; status drives user outputs.

Parameters:
- CODE_W, 5, bits per digit.
- N_STEPS, 3, digits per code (>=2).
- DEFAULT_CODE, {5'h1D,5'h0C,5'h10}, reset code (N_STEPS*CODE_W bits); digit i is in bits [i*CODE_W +: CODE_W], so digit 0 is in the LSBs.
- MAX_FAIL, 3, consecutive wrong digits before lockout (>=1).
- LOCKOUT_CYC, 16, lockout duration in clocks (>=1).
- UNLOCK_CYC, 8, unlock window in clocks (>=1).

Ports:
- clk  in  1  single system clock, all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- code_in  in  CODE_W  current digit.
- enter  in  1  digit strobe (level); its rising edge is internally detected.
- prog_en  in  1  program-mode request.
- unlocked  out  1  high for the unlock window.
- locked_out  out  1  high during lockout.
- prog_active  out  1  high in program mode.
- step  out  $clog2(N_STEPS)  index of the next digit expected (entry or program).
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=ENTRY, step=0, fail_cnt=0, timer=0, enter_q=0;
  - code_mem=DEFAULT_CODE, shadow=0;
  - all outputs 0.
  - Reset mid-operation discards any program in progress and restores DEFAULT_CODE.
- Strobe edge detect: edge = enter & ~enter_q, where enter_q is a registered copy of enter.
  - Edge is evaluated combinationally in the cycle enter first samples high.
  - The state update appears one clock later; latency from enter rising to an output change is 1 clock.
  - Holding enter high gives exactly one edge.
- All outputs are registered, or decoded directly from registered state.
- ENTRY:
  - No edge -> hold.
  - Edge with code_in==code_mem[step]:
    - step<N_STEPS-1 -> step++.
    - step==N_STEPS-1 -> UNLOCKED, step=0, fail_cnt=0, timer=UNLOCK_CYC-1.
  - Edge with mismatch:
    - step=0 (restart sequence; the mismatching digit is not re-evaluated as digit 0).
    - If fail_cnt+1==MAX_FAIL -> LOCKOUT, timer=LOCKOUT_CYC-1, fail_cnt=0.
    - Else fail_cnt++.
  - prog_en is ignored in ENTRY.
- UNLOCKED: unlocked=1.
  - Edge with prog_en=1 -> PROGRAM, step=0. This has priority over timer expiry in the same cycle.
  - Otherwise, timer==0 -> ENTRY; else timer--.
  - Edges with prog_en=0 are ignored.
- PROGRAM: prog_active=1; the timer is not running.
  - prog_en=0 -> abort to ENTRY, step=0, shadow discarded, code_mem unchanged. Abort has priority over an edge in the same cycle.
  - Edge -> shadow[step]=code_in.
    - step<N_STEPS-1 -> step++.
    - Last digit -> code_mem takes all shadow digits plus the current code_in atomically in one clock, then ENTRY, step=0.
- LOCKOUT: locked_out=1.
  - All edges ignored; they do not count as failures.
  - timer==0 -> ENTRY; else timer--.
- Window durations:
  - unlocked is high for exactly UNLOCK_CYC clocks absent programming.
  - locked_out is high for exactly LOCKOUT_CYC clocks.
- Comparisons are full-width CODE_W equality.
- Timer width: $clog2(max(UNLOCK_CYC,LOCKOUT_CYC)+1).
- No wrap-around:
  - step never exceeds N_STEPS-1;
  - fail_cnt never reaches MAX_FAIL (it is cleared on entering lockout).

Decomposition:
- Shared package seq_lock_pkg:
  - state enum (ENTRY, UNLOCKED, PROGRAM, LOCKOUT, 2-bit encoding);
  - width helper functions (step, fail and timer widths).
- One natural sub-module: edge_detect_rise (a registered input plus a rising-edge pulse, same reset). It is reusable across tiles.
- The code store, sequencing FSM and timer stay in seq_lock.

Test Plan:
- Default unlock: after reset, strobe 0x10, 0x0C, 0x1D -> unlocked rises 1 clk after the third edge, stays high 8 clks, then ENTRY; fail_cnt=0.
- Mismatch restart: strobe 0x10, then 0x0C (correct), then 0x01 -> step goes 0,1,2,0; fail_cnt=1. The following full 0x10, 0x0C, 0x1D -> unlocked, fail_cnt=0.
- Lockout: three wrong digits 0x00 -> locked_out high for 16 clks. Correct sequence strobed during lockout -> no unlock, fail_cnt stays 0. After lockout, a correct sequence unlocks.
- Strobe held: enter held high 10 clks with code 0x10 -> step=1 only, no further advance.
- Reprogram: unlock, then with prog_en=1 give an edge, then strobe 0x05, 0x0A, 0x15 -> prog_active drops after the last digit. Old code 0x10, 0x0C, 0x1D then fails; 0x05, 0x0A, 0x15 unlocks.
- Abort and reset:
  - Drop prog_en after 2 program digits -> code unchanged.
  - Assert rst_n low mid-PROGRAM asynchronously -> all outputs 0 immediately; DEFAULT_CODE restored and unlocks.
